// File: rtl/frame_timer_pkg.sv
// Shared definitions for the frame timer: register map, CTRL bit positions
// and FSM state encoding.
package frame_timer_pkg;

  localparam logic [1:0] ADDR_LOAD   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_AUTO  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the CPU clock down to the timer tick: one-cycle tick every
// PRESCALE_DIV enabled clocks, restartable with a synchronous clear.
module tick_prescaler #(
  parameter int unsigned PRESCALE_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
  end

  assign tick = enable & ~clear & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_timer.sv
// Memory-mapped 16-bit countdown timer with sticky expiry flag and a
// saturating missed-expiry counter, read-cleared through STATUS.
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 1000,
  parameter int unsigned MISS_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        read,
  input  logic [1:0]  addr,
  inout  logic [15:0] DataBus
);

  state_e              state_q;
  logic [15:0]         load_q;
  logic [15:0]         count_q;
  logic                autoreload_q;
  logic                expired_q;
  logic [MISS_W-1:0]   missed_q;
  logic                rd_q;

  logic        wr, rd;
  logic        wr_load, wr_ctrl;
  logic        start, stop;
  logic        status_clr;
  logic        tick;
  logic        expire;
  logic [7:0]  missed8;
  logic [15:0] rdata;

  assign wr         = cs & ~read;
  assign rd         = cs & read;
  assign wr_load    = wr & (addr == ADDR_LOAD);
  assign wr_ctrl    = wr & (addr == ADDR_CTRL);
  assign start      = wr_ctrl & DataBus[CTRL_START];
  assign stop       = wr_ctrl & DataBus[CTRL_STOP];
  assign status_clr = rd & ~rd_q & (addr == ADDR_STATUS);

  // CPU start/stop writes take priority over a tick landing on the same edge.
  assign expire = tick & ~start & ~stop & (count_q <= 16'd1);

  tick_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (start & ~stop),
    .enable(state_q == RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      load_q       <= '0;
      count_q      <= '0;
      autoreload_q <= 1'b0;
      expired_q    <= 1'b0;
      missed_q     <= '0;
      rd_q         <= 1'b0;
    end else begin
      rd_q <= rd;
      if (wr_load) load_q <= DataBus;

      if (stop) begin
        state_q <= IDLE;
      end else if (start) begin
        autoreload_q <= DataBus[CTRL_AUTO];
        // A zero reload never runs; a running timer simply halts in place.
        if (load_q != '0) begin
          state_q <= RUN;
          count_q <= load_q;
        end else begin
          state_q <= IDLE;
        end
      end else if (tick) begin
        if (count_q > 16'd1) begin
          count_q <= count_q - 16'd1;
        end else if (autoreload_q && (load_q != '0)) begin
          count_q <= load_q;
        end else begin
          count_q <= '0;
          state_q <= IDLE;
        end
      end

      if (expire)          expired_q <= 1'b1;
      else if (status_clr) expired_q <= 1'b0;

      if (status_clr)
        missed_q <= '0;
      else if (expire && expired_q && (missed_q != '1))
        missed_q <= missed_q + 1'b1;
    end
  end

  assign missed8 = 8'(missed_q);

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_LOAD:   rdata = load_q;
      ADDR_CTRL:   rdata = {13'b0, autoreload_q, (state_q == RUN), 1'b0};
      ADDR_COUNT:  rdata = count_q;
      ADDR_STATUS: rdata = {missed8, 7'b0, expired_q};
      default:     rdata = '0;
    endcase
  end

  assign DataBus = rd ? rdata : 16'bz;

endmodule

// File: tb/tb_frame_timer.sv
// Randomized self-checking bench for frame_timer with an arithmetic model
// of count/expiry derived from elapsed clocks since the last start.
module tb_frame_timer;

  localparam int unsigned DIV = 4;
  localparam logic [1:0] A_LOAD = 2'd0, A_CTRL = 2'd1, A_COUNT = 2'd2, A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        drv = 1'b0;
  logic [15:0] dat = 16'h0000;
  wire  [15:0] DataBus;

  assign DataBus = drv ? dat : 16'hzzzz;
  pullup (DataBus);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cyc_s = 0;

  frame_timer #(.PRESCALE_DIV(DIV), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .addr(addr), .DataBus(DataBus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (elapsed-time arithmetic) ----------------
  function automatic int m_count(input int L, input bit ar, input int e);
    int t;
    t = e / DIV;
    if (ar) return L - (t % L);
    return (t >= L) ? 0 : L - t;
  endfunction

  function automatic int m_expiries(input int L, input bit ar, input int e);
    int t;
    t = e / DIV;
    if (ar) return t / L;
    return (t >= L) ? 1 : 0;
  endfunction

  function automatic logic [15:0] m_status(input int L, input bit ar, input int e);
    int n;
    logic [7:0] m;
    n = m_expiries(L, ar, e);
    if (n == 0) return 16'h0000;
    m = (n - 1 > 255) ? 8'hFF : 8'(n - 1);
    return {m, 7'b0, 1'b1};
  endfunction

  function automatic logic [15:0] m_ctrl(input int L, input bit ar, input int e);
    bit running;
    running = ar ? 1'b1 : ((e / DIV) < L);
    return {13'b0, ar, running, 1'b0};
  endfunction

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b0; addr = a; dat = d; drv = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d, output int at);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = DataBus; at = cyc - cyc_s;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
  endtask

  // One idle edge first so the read-clear edge detect sees a fresh access.
  task automatic read_status(output logic [15:0] d, output int at);
    @(posedge clk); #1;
    bus_read(A_STATUS, d, at);
  endtask

  task automatic start(input bit ar);
    bus_write(A_CTRL, {13'b0, ar, 1'b0, 1'b1});
    cyc_s = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc - cyc_s < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic quiesce();
    logic [15:0] d;
    int at;
    bus_write(A_CTRL, 16'h0002);
    read_status(d, at);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] d;
    int at;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int unsigned a = 0; a < 4; a++) begin
      bus_read(2'(a), d, at);
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0000", a, d); end
    end
    #2;
    checks++; if (DataBus !== 16'hFFFF) begin failures++; $display("FAIL reset_hiz got=%h exp=ffff(pulled)", DataBus); end
  endtask

  task automatic test_bus();
    logic [15:0] d;
    int at;
    bus_write(A_LOAD, 16'h1234);
    @(negedge clk); cs = 1'b0; read = 1'b1; addr = A_LOAD; #1;
    checks++; if (DataBus !== 16'hFFFF) begin failures++; $display("FAIL hiz_nocs got=%h exp=ffff", DataBus); end
    @(negedge clk); cs = 1'b1; read = 1'b0; addr = A_COUNT; dat = 16'h00F0; drv = 1'b1; #1;
    checks++; if (DataBus !== 16'h00F0) begin failures++; $display("FAIL hiz_write got=%h exp=00f0", DataBus); end
    @(posedge clk); #1; addr = A_STATUS; dat = 16'hFF01;
    @(posedge clk); #1; cs = 1'b0; drv = 1'b0; read = 1'b0;
    bus_read(A_COUNT, d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL count_write_ignored got=%h exp=0000", d); end
    read_status(d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL status_write_ignored got=%h exp=0000", d); end
    bus_read(A_LOAD, d, at);
    checks++; if (d !== 16'h1234) begin failures++; $display("FAIL load_readback got=%h exp=1234", d); end
  endtask

  task automatic test_oneshot();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd3);
    start(1'b0);
    for (int i = 0; i < 14; i++) begin
      bus_read(A_COUNT, d, at);
      checks++; if (d !== 16'(m_count(3, 1'b0, at))) begin failures++; $display("FAIL oneshot_count e=%0d got=%0d exp=%0d", at, d, m_count(3, 1'b0, at)); end
    end
    bus_read(A_CTRL, d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL oneshot_ctrl got=%h exp=0000", d); end
    read_status(d, at);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL oneshot_status got=%h exp=0001", d); end
    read_status(d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL oneshot_status2 got=%h exp=0000", d); end
  endtask

  task automatic test_autoreload_miss();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd2);
    start(1'b1);
    wait_until(39);
    read_status(d, at);
    checks++; if (d !== m_status(2, 1'b1, at)) begin failures++; $display("FAIL auto_miss_status e=%0d got=%h exp=%h", at, d, m_status(2, 1'b1, at)); end
  endtask

  task automatic test_zero_and_stop();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd0);
    bus_write(A_CTRL, 16'h0005);
    bus_read(A_CTRL, d, at);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL zero_ctrl_auto got=%h exp=0004", d); end
    bus_write(A_CTRL, 16'h0001);
    bus_read(A_CTRL, d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL zero_ctrl got=%h exp=0000", d); end
    read_status(d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL zero_status got=%h exp=0000", d); end
    bus_write(A_LOAD, 16'd5);
    start(1'b0);
    wait_until(5);
    bus_write(A_CTRL, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_COUNT, d, at);
      checks++; if (d !== 16'd4) begin failures++; $display("FAIL stop_frozen i=%0d got=%0d exp=4", i, d); end
      repeat (10) @(posedge clk);
      #1;
    end
    read_status(d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL stop_status got=%h exp=0000", d); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd2);
    start(1'b1);
    wait_until(30);
    read_status(d, at);
    checks++; if (d !== m_status(2, 1'b1, at)) begin failures++; $display("FAIL collide_first e=%0d got=%h exp=%h", at, d, m_status(2, 1'b1, at)); end
    checks++; if (d !== 16'h0201) begin failures++; $display("FAIL collide_value got=%h exp=0201", d); end
    read_status(d, at);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL collide_second got=%h exp=0001", d); end
  endtask

  task automatic test_restart();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd10);
    start(1'b0);
    wait_until(8);
    bus_write(A_LOAD, 16'd3);
    bus_read(A_COUNT, d, at);
    checks++; if (d !== 16'(m_count(10, 1'b0, at))) begin failures++; $display("FAIL restart_pre got=%0d exp=%0d", d, m_count(10, 1'b0, at)); end
    start(1'b0);
    for (int i = 0; i < 14; i++) begin
      bus_read(A_COUNT, d, at);
      checks++; if (d !== 16'(m_count(3, 1'b0, at))) begin failures++; $display("FAIL restart_count e=%0d got=%0d exp=%0d", at, d, m_count(3, 1'b0, at)); end
    end
    read_status(d, at);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL restart_status got=%h exp=0001", d); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    int at, L, w;
    bit ar;
    for (int it = 0; it < 8; it++) begin
      L  = int'($urandom_range(1, 6));
      ar = 1'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 45));
      quiesce();
      bus_write(A_LOAD, 16'(L));
      start(ar);
      wait_until(w);
      bus_read(A_COUNT, d, at);
      checks++; if (d !== 16'(m_count(L, ar, at))) begin failures++; $display("FAIL rand_count L=%0d ar=%0d e=%0d got=%0d exp=%0d", L, ar, at, d, m_count(L, ar, at)); end
      bus_read(A_CTRL, d, at);
      checks++; if (d !== m_ctrl(L, ar, at)) begin failures++; $display("FAIL rand_ctrl L=%0d ar=%0d e=%0d got=%h exp=%h", L, ar, at, d, m_ctrl(L, ar, at)); end
      read_status(d, at);
      checks++; if (d !== m_status(L, ar, at)) begin failures++; $display("FAIL rand_status L=%0d ar=%0d e=%0d got=%h exp=%h", L, ar, at, d, m_status(L, ar, at)); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] d;
    int at;
    quiesce();
    bus_write(A_LOAD, 16'd3);
    start(1'b1);
    wait_until(10);
    @(negedge clk); rst = 1'b0;
    #1 cs = 1'b1; read = 1'b1; addr = A_COUNT;
    #1;
    checks++; if (DataBus !== 16'h0000) begin failures++; $display("FAIL async_reset_count got=%h exp=0000", DataBus); end
    cs = 1'b0; read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int unsigned a = 0; a < 4; a++) begin
      bus_read(2'(a), d, at);
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midrun_reg%0d got=%h exp=0000", a, d); end
    end
    repeat (40) @(posedge clk);
    read_status(d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midrun_noexpiry got=%h exp=0000", d); end
    bus_read(A_COUNT, d, at);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midrun_count got=%h exp=0000", d); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_oneshot();
    test_autoreload_miss();
    test_zero_and_stop();
    test_collision();
    test_restart();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
